div_seq: RTL and testbench



---
 rtl/div_pkg.sv | 22 ++
 rtl/div_step.sv | 23 ++
 rtl/div_seq.sv | 156 +++++++++++++++
 tb/tb_div_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and elaboration helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Width of the iteration counter that must hold ITER-1 = N/S - 1.
  function automatic int cnt_width(input int n, input int s);
    int iter;
    if (s < 1) return 1;
    iter = n / s;
    return (iter <= 1) ? 1 : $clog2(iter);
  endfunction

  function automatic bit params_ok(input int n, input int s);
    return (n >= 2) && (s >= 1) && (s <= n) && ((n % s) == 0);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring step: shift in a dividend bit, trial-subtract, select.
module div_step #(
  parameter int N = 16
) (
  input  logic [N-1:0] rem,
  input  logic         bit_in,
  input  logic [N-1:0] div,
  output logic [N-1:0] rem_next,
  output logic         q_bit
);

  logic [N-1:0] shifted_lo;
  logic [N-1:0] diff;
  logic         borrow_lo;

  // The shifted value is N+1 bits wide; its top bit is rem[N-1]. When that bit is
  // set the shifted value exceeds any N-bit divisor, so the subtraction cannot borrow.
  assign shifted_lo          = {rem[N-2:0], bit_in};
  assign {borrow_lo, diff}   = {1'b0, shifted_lo} - {1'b0, div};
  assign q_bit               = rem[N-1] | ~borrow_lo;
  assign rem_next            = q_bit ? diff : shifted_lo;

endmodule

// File: rtl/div_seq.sv
// Iterative N-bit restoring divider, S quotient bits per clock, signed/unsigned per request.
module div_seq
  import div_pkg::*;
#(
  parameter int N = 16,
  parameter int S = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_sgn,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_q,
  output logic [N-1:0]   out_r,
  output logic           out_dbz,
  output logic           out_ovf,
  output div_state_e     dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; in_ready is high only in IDLE, out_valid only in DONE.

  localparam int ITER = N / S;
  localparam int CW   = cnt_width(N, S);
  localparam logic [CW-1:0] CNT_LOAD = CW'(ITER - 1);
  localparam logic [N-1:0]  MOST_NEG = {1'b1, {(N-1){1'b0}}};

  if (!params_ok(N, S)) begin : g_bad_params
    $error("div_seq: N must be >= 2 and S must divide N evenly");
  end

  div_state_e    state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  a_reg;
  logic [N-1:0]  b_reg;
  logic [N-1:0]  rem;
  logic          neg_q;
  logic          neg_r;
  logic          dbz_r;
  logic          ovf_r;

  logic          a_neg;
  logic          b_neg;
  logic          in_dbz;
  logic          in_ovf;
  logic [N-1:0]  a_mag;
  logic [N-1:0]  b_mag;
  logic [N-1:0]  q_raw;
  logic [N-1:0]  r_raw;
  logic [N-1:0]  q_fix;
  logic [N-1:0]  r_fix;

  assign a_neg  = in_sgn & in_a[N-1];
  assign b_neg  = in_sgn & in_b[N-1];
  assign a_mag  = a_neg ? -in_a : in_a;
  assign b_mag  = b_neg ? -in_b : in_b;
  assign in_dbz = (in_b == '0);
  assign in_ovf = in_sgn & (in_a == MOST_NEG) & (&in_b);

  // a_reg doubles as the dividend shift register and the quotient accumulator.
  for (genvar k = 0; k < S; k++) begin : g_step
    logic [N-1:0] a_i;
    logic [N-1:0] r_i;
    logic [N-1:0] a_o;
    logic [N-1:0] r_o;
    logic         qb;
    if (k == 0) begin : g_first
      assign a_i = a_reg;
      assign r_i = rem;
    end else begin : g_next
      assign a_i = g_step[k-1].a_o;
      assign r_i = g_step[k-1].r_o;
    end
    div_step #(.N(N)) u_step (
      .rem      (r_i),
      .bit_in   (a_i[N-1]),
      .div      (b_reg),
      .rem_next (r_o),
      .q_bit    (qb)
    );
    assign a_o = {a_i[N-2:0], qb};
  end

  assign q_raw = g_step[S-1].a_o;
  assign r_raw = g_step[S-1].r_o;
  assign q_fix = neg_q ? -q_raw : q_raw;
  assign r_fix = neg_r ? -r_raw : r_raw;

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_q     <= '0;
      out_r     <= '0;
      out_dbz   <= 1'b0;
      out_ovf   <= 1'b0;
      cnt       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      rem       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dbz_r     <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // A zero divisor runs on the raw dividend: restoring with b=0 yields
            // q = all ones and r = a naturally, so no sign fix-up is applied.
            a_reg    <= in_dbz ? in_a : a_mag;
            b_reg    <= b_mag;
            rem      <= '0;
            cnt      <= CNT_LOAD;
            neg_q    <= ~in_dbz & (a_neg ^ b_neg);
            neg_r    <= ~in_dbz & a_neg;
            dbz_r    <= in_dbz;
            ovf_r    <= in_ovf;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_reg <= q_raw;
          rem   <= r_raw;
          if (cnt == '0) begin
            out_q     <= q_fix;
            out_r     <= r_fix;
            out_dbz   <= dbz_r;
            out_ovf   <= ovf_r;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq (N=16/S=1 and N=32/S=4 instances).
module tb_div_seq;
  import div_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        in_valid16, in_ready16, in_sgn16, out_valid16, out_ready16, out_dbz16, out_ovf16;
  logic [15:0] in_a16, in_b16, out_q16, out_r16;
  div_state_e  dbg16;

  logic        in_valid32, in_ready32, in_sgn32, out_valid32, out_ready32, out_dbz32, out_ovf32;
  logic [31:0] in_a32, in_b32, out_q32, out_r32;
  div_state_e  dbg32;

  div_seq #(.N(16), .S(1)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16), .in_sgn(in_sgn16),
    .in_a(in_a16), .in_b(in_b16), .out_valid(out_valid16), .out_ready(out_ready16),
    .out_q(out_q16), .out_r(out_r16), .out_dbz(out_dbz16), .out_ovf(out_ovf16), .dbg_state(dbg16)
  );

  div_seq #(.N(32), .S(4)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32), .in_sgn(in_sgn32),
    .in_a(in_a32), .in_b(in_b32), .out_valid(out_valid32), .out_ready(out_ready32),
    .out_q(out_q32), .out_r(out_r32), .out_dbz(out_dbz32), .out_ovf(out_ovf32), .dbg_state(dbg32)
  );

  // Driver: present one request, wait for acceptance and then for out_valid.
  // Called #1 after a rising edge; returns #1 after the edge that raised out_valid.
  task automatic run16(input logic sgn, input logic [15:0] a, input logic [15:0] b,
                       output int lat, output logic [33:0] res);
    int guard = 0;
    while (!in_ready16 && guard < 100) begin @(posedge clk); #1; guard++; end
    in_valid16 = 1'b1; in_sgn16 = sgn; in_a16 = a; in_b16 = b;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    lat = 0;
    while (!out_valid16 && lat < 100) begin @(posedge clk); #1; lat++; end
    res = {out_q16, out_r16, out_dbz16, out_ovf16};
  endtask

  task automatic run32(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [65:0] res);
    int guard = 0;
    while (!in_ready32 && guard < 100) begin @(posedge clk); #1; guard++; end
    in_valid32 = 1'b1; in_sgn32 = sgn; in_a32 = a; in_b32 = b;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    lat = 0;
    while (!out_valid32 && lat < 100) begin @(posedge clk); #1; lat++; end
    res = {out_q32, out_r32, out_dbz32, out_ovf32};
  endtask

  task automatic test_reset();
    checks++;
    if ({out_valid16, in_ready16, out_q16, out_r16, out_dbz16, out_ovf16} !== {1'b0, 1'b1, 34'd0}) begin
      errors++; $display("FAIL reset16 got v=%b rdy=%b q=%h r=%h dbz=%b ovf=%b want v=0 rdy=1 rest 0",
                         out_valid16, in_ready16, out_q16, out_r16, out_dbz16, out_ovf16);
    end
    checks++;
    if ({out_valid32, in_ready32, out_q32, out_r32, out_dbz32, out_ovf32} !== {1'b0, 1'b1, 66'd0}) begin
      errors++; $display("FAIL reset32 got v=%b rdy=%b q=%h r=%h want v=0 rdy=1 rest 0",
                         out_valid32, in_ready32, out_q32, out_r32);
    end
    checks++;
    if (dbg16 !== IDLE || dbg32 !== IDLE) begin
      errors++; $display("FAIL reset_state got %0d/%0d want IDLE", dbg16, dbg32);
    end
  endtask

  task automatic test_unsigned();
    int lat; logic [33:0] res;
    run16(1'b0, 16'd100, 16'd7, lat, res);
    checks++;
    if (lat !== 16) begin errors++; $display("FAIL unsigned_latency got %0d want 16", lat); end
    checks++;
    if (res !== {16'd14, 16'd2, 2'b00}) begin
      errors++; $display("FAIL unsigned_100_7 got %h want %h", res, {16'd14, 16'd2, 2'b00});
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid16 !== 1'b0 || in_ready16 !== 1'b1) begin
      errors++; $display("FAIL unsigned_drain got v=%b rdy=%b want v=0 rdy=1", out_valid16, in_ready16);
    end
    run16(1'b0, 16'hFFF9, 16'd2, lat, res);
    checks++;
    if (res !== {16'h7FFC, 16'h0001, 2'b00}) begin
      errors++; $display("FAIL unsigned_fff9_2 got %h want %h", res, {16'h7FFC, 16'h0001, 2'b00});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_dbz();
    int lat; logic [33:0] res;
    run16(1'b0, 16'h1234, 16'h0000, lat, res);
    checks++;
    if (res !== {16'hFFFF, 16'h1234, 2'b10}) begin
      errors++; $display("FAIL dbz_unsigned got %h want %h", res, {16'hFFFF, 16'h1234, 2'b10});
    end
    @(posedge clk); #1;
    run16(1'b1, 16'hFFF9, 16'h0000, lat, res);
    checks++;
    if (res !== {16'hFFFF, 16'hFFF9, 2'b10}) begin
      errors++; $display("FAIL dbz_signed got %h want %h", res, {16'hFFFF, 16'hFFF9, 2'b10});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_signed();
    int lat; logic [33:0] res;
    run16(1'b1, 16'hFFF9, 16'h0002, lat, res);
    checks++;
    if (res !== {16'hFFFD, 16'hFFFF, 2'b00}) begin
      errors++; $display("FAIL signed_m7_2 got %h want %h", res, {16'hFFFD, 16'hFFFF, 2'b00});
    end
    @(posedge clk); #1;
    run16(1'b1, 16'h0007, 16'hFFFE, lat, res);
    checks++;
    if (res !== {16'hFFFD, 16'h0001, 2'b00}) begin
      errors++; $display("FAIL signed_7_m2 got %h want %h", res, {16'hFFFD, 16'h0001, 2'b00});
    end
    @(posedge clk); #1;
    run16(1'b1, 16'hFFF9, 16'hFFFE, lat, res);
    checks++;
    if (res !== {16'h0003, 16'hFFFF, 2'b00}) begin
      errors++; $display("FAIL signed_m7_m2 got %h want %h", res, {16'h0003, 16'hFFFF, 2'b00});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ovf();
    int lat; logic [33:0] res;
    run16(1'b1, 16'h8000, 16'hFFFF, lat, res);
    checks++;
    if (res !== {16'h8000, 16'h0000, 2'b01}) begin
      errors++; $display("FAIL signed_ovf got %h want %h", res, {16'h8000, 16'h0000, 2'b01});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int lat; logic [33:0] res;
    out_ready16 = 1'b0;
    run16(1'b0, 16'd1000, 16'd10, lat, res);
    checks++;
    if (res !== {16'd100, 16'd0, 2'b00}) begin
      errors++; $display("FAIL bp_result got %h want %h", res, {16'd100, 16'd0, 2'b00});
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid16, in_ready16, out_q16, out_r16, out_dbz16, out_ovf16} !== {1'b1, 1'b0, 16'd100, 16'd0, 2'b00}) begin
        errors++; $display("FAIL bp_hold cycle %0d got v=%b rdy=%b q=%h r=%h want v=1 rdy=0 q=0064 r=0000",
                           i, out_valid16, in_ready16, out_q16, out_r16);
      end
    end
    out_ready16 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid16 !== 1'b0 || in_ready16 !== 1'b1) begin
      errors++; $display("FAIL bp_release got v=%b rdy=%b want v=0 rdy=1", out_valid16, in_ready16);
    end
    run16(1'b0, 16'hFFFF, 16'h0100, lat, res);
    checks++;
    if (lat !== 16 || res !== {16'h00FF, 16'h00FF, 2'b00}) begin
      errors++; $display("FAIL bp_next got lat=%0d res=%h want lat=16 res=%h", lat, res, {16'h00FF, 16'h00FF, 2'b00});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op();
    int lat; int seen; logic [65:0] res;
    in_valid16 = 1'b1; in_sgn16 = 1'b0; in_a16 = 16'd500; in_b16 = 16'd3;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid16 !== 1'b0 || in_ready16 !== 1'b1 || dbg16 !== IDLE) begin
      errors++; $display("FAIL mid_reset got v=%b rdy=%b st=%0d want v=0 rdy=1 IDLE", out_valid16, in_ready16, dbg16);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid16) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL mid_reset_no_result got %0d valid cycles want 0", seen); end
    run32(1'b0, 32'hFFFFFFFF, 32'h00000010, lat, res);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL n32_latency got %0d want 8", lat); end
    checks++;
    if (res !== {32'h0FFFFFFF, 32'h0000000F, 2'b00}) begin
      errors++; $display("FAIL n32_result got %h want %h", res, {32'h0FFFFFFF, 32'h0000000F, 2'b00});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid16 = 1'b0; in_sgn16 = 1'b0; in_a16 = '0; in_b16 = '0; out_ready16 = 1'b1;
    in_valid32 = 1'b0; in_sgn32 = 1'b0; in_a32 = '0; in_b32 = '0; out_ready32 = 1'b1;
    #23;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_unsigned();
    test_dbz();
    test_signed();
    test_ovf();
    test_backpressure();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
